// File: rtl/imm_encoder_if.sv
// Request/result bundle for the immediate encoder: template + immediate in, encoded word out.
// Both directions use valid/ready; the master side issues requests and consumes results.
// Clock and reset are not carried here; they stay plain ports on the encoder.
interface imm_encoder_if #(
  parameter int XLEN = 64
);
  logic            io_in_valid;
  logic            io_in_ready;
  logic [2:0]      io_in_fmt;
  logic [31:0]     io_in_base;
  logic [XLEN-1:0] io_in_imm;
  logic            io_out_valid;
  logic            io_out_ready;
  logic [31:0]     io_out_instruction;
  logic            io_out_error;
  logic            io_out_last;

  modport master (
    output io_in_valid, io_in_fmt, io_in_base, io_in_imm, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_instruction, io_out_error, io_out_last
  );

  modport slave (
    input  io_in_valid, io_in_fmt, io_in_base, io_in_imm, io_out_ready,
    output io_in_ready, io_out_valid, io_out_instruction, io_out_error, io_out_last
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a signed immediate into the I/S/B/U/J fields of a template instruction word.
// Latency 1 cycle accept->result; output registers hold while valid & !ready, input stalls then.
// Optional IMM_ENC_SPLIT_EN: wide I-type immediates become LUI + I-type pair (two beats).
module imm_encoder #(
  parameter int XLEN = 64
) (
  input logic       clock,
  input logic       reset,
  imm_encoder_if.slave bus
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
  localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
  localparam logic [31:0] MASK_UJ = 32'hFFFF_F000;

  typedef enum logic {IDLE, HOLD_LO} state_t;

  state_t      state;
  logic        out_valid;
  logic [31:0] out_instr;
  logic        out_error;
  logic        out_last;

  logic [XLEN-1:0] imm;
  logic [31:0]     base;
  logic            fit12, fit13, fit21, fit32;
  logic [31:0]     enc_instr;
  logic            enc_error;
  logic            enc_split;
  logic [31:0]     lo_instr;
  logic            in_fire;

  assign imm  = bus.io_in_imm;
  assign base = bus.io_in_base;

  // A value fits in n signed bits when every bit from n-1 upward equals the sign bit.
  assign fit12 = (imm[XLEN-1:11] == {(XLEN-11){imm[11]}});
  assign fit13 = (imm[XLEN-1:12] == {(XLEN-12){imm[12]}});
  assign fit21 = (imm[XLEN-1:20] == {(XLEN-20){imm[20]}});
  assign fit32 = (imm[XLEN-1:31] == {(XLEN-31){imm[31]}});

  assign bus.io_in_ready = (state == IDLE) && (!out_valid || bus.io_out_ready);
  assign in_fire         = bus.io_in_valid && bus.io_in_ready;

  // Mask the template's immediate fields and OR in the encoding; on error only the masked base goes out.
  always_comb begin
    enc_instr = base;
    enc_error = 1'b1;
    enc_split = 1'b0;
    lo_instr  = 32'h0;
    case (bus.io_in_fmt)
      FMT_I: begin
        enc_error = !fit12;
        enc_instr = (base & ~MASK_I) | (fit12 ? {imm[11:0], 20'h0} : 32'h0);
`ifdef IMM_ENC_SPLIT_EN
        if (!fit12 && fit32) begin
          // LUI rd,hi then addi-style rd,rd,lo; hi is rounded so the sign-extended lo lands exactly.
          enc_error = 1'b0;
          enc_split = 1'b1;
          enc_instr = {imm[31:12] + {19'h0, imm[11]}, base[11:7], 7'b0110111};
          lo_instr  = (base & ~MASK_I & ~32'h000F_8000) | {imm[11:0], 20'h0}
                      | {12'h0, base[11:7], 15'h0};
        end
`endif
      end
      FMT_S: begin
        enc_error = !fit12;
        enc_instr = (base & ~MASK_SB)
                    | (fit12 ? {imm[11:5], 13'h0, imm[4:0], 7'h0} : 32'h0);
      end
      FMT_B: begin
        enc_error = !(fit13 && !imm[0]);
        enc_instr = (base & ~MASK_SB)
                    | (enc_error ? 32'h0
                                 : {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0});
      end
      FMT_U: begin
        enc_error = !(fit32 && (imm[11:0] == 12'h0));
        enc_instr = (base & ~MASK_UJ) | (enc_error ? 32'h0 : {imm[31:12], 12'h0});
      end
      FMT_J: begin
        enc_error = !(fit21 && !imm[0]);
        enc_instr = (base & ~MASK_UJ)
                    | (enc_error ? 32'h0 : {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0});
      end
      default: begin
        enc_error = 1'b1;
        enc_instr = base;
      end
    endcase
  end

`ifdef IMM_ENC_SPLIT_EN
  logic [31:0] hold_instr;

  // Second beat of a split is parked here until the first beat is consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          hold_instr <= 32'h0;
    else if (in_fire && enc_split)       hold_instr <= lo_instr;
  end
`endif

  // Output stage and beat sequencing: load on accept, hold under backpressure, advance split beats.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_error <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            out_valid <= 1'b1;
            out_instr <= enc_instr;
            out_error <= enc_error;
            out_last  <= !enc_split;
            if (enc_split) state <= HOLD_LO;
          end else if (bus.io_out_ready) begin
            out_valid <= 1'b0;
          end
        end
`ifdef IMM_ENC_SPLIT_EN
        HOLD_LO: begin
          if (bus.io_out_ready) begin
            out_instr <= hold_instr;
            out_error <= 1'b0;
            out_last  <= 1'b1;
            state     <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.io_out_valid       = out_valid;
  assign bus.io_out_instruction = out_instr;
  assign bus.io_out_error       = out_error;
  assign bus.io_out_last        = out_last;

endmodule
